res_arb: RTL and testbench
==========================

RES_ARB -- requirements
Module: res_arb

Interface
REQ-001 Parameters: AW, 14, res_RAM address width; DW, 8, res_RAM data width.
REQ-002 Ports:
- clk  in  1  sole clock; all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_a / req_b  in  1  requester A/B access request.
- wr_a / wr_b  in  1  1 = write, 0 = read.
- addr_a / addr_b  in  AW  target address.
- wdata_a / wdata_b  in  DW  write data.
- lock_a / lock_b  in  1  hold-grant request (see Configuration).
- gnt_a / gnt_b  out  1  combinational grant; request consumed at the closing posedge.
- rvalid_a / rvalid_b  out  1  one-cycle read-data-valid pulse.
- rdata_a / rdata_b  out  DW  read data, valid while rvalid is high.
- res_rd  out  1  RAM read strobe; RAM samples it on negedge.
- res_wr  out  1  RAM write strobe; RAM writes on posedge.
- res_addr  out  AW  RAM address.
- res_do  out  DW  RAM write data.
- res_di  in  DW  RAM read data, valid after the negedge of the res_rd cycle.
- busy  out  1  high while a command is on the RAM port or a read return is pending.

Function
REQ-003 At most one of gnt_a and gnt_b SHALL be high in any cycle; gnt_x SHALL be high only when req_x is high.
REQ-004 Single requester: it SHALL be granted in the same cycle, giving one access per cycle sustained.
REQ-005 Both requesting: grant SHALL go to the requester not granted most recently (round-robin); the last-grant pointer SHALL update only on a grant.
REQ-006 Grant in cycle c SHALL drive registered res_rd or res_wr, res_addr and res_do in cycle c+1 from the values sampled at the closing edge of c.
REQ-007 When no grant occurs in cycle c, res_rd and res_wr SHALL both be 0 in c+1; res_addr and res_do SHALL hold their previous values.
REQ-008 For a read granted in c: rdata_x SHALL capture res_di at the posedge ending c+1, and rvalid_x SHALL be high for exactly cycle c+2.
REQ-009 Read latency SHALL be fixed at 2 cycles from grant to rvalid; writes SHALL produce no rvalid.
REQ-010 Commands SHALL reach the RAM in grant order, so a read granted after a write to the same address returns the new data.
REQ-011 Reads from A and B SHALL be tagged internally so that each rvalid returns only to its issuer; rvalid_a and rvalid_b SHALL never be high together.
REQ-012 busy SHALL equal (res_rd | res_wr | any rvalid pending).

Reset
REQ-013 Asserting reset SHALL immediately force to 0: res_rd, res_wr, res_addr, res_do, rvalid_a, rvalid_b, rdata_a, rdata_b and busy.
REQ-014 Reset SHALL set the last-grant pointer to B so that A wins the first contention, and SHALL clear the lock state.
REQ-015 Reset mid-operation SHALL drop in-flight commands and pending read returns, with no rvalid issued after reset releases.
REQ-016 gnt_a and gnt_b SHALL be 0 while reset is high.

Configuration
REQ-017 Macro RES_ARB_LOCK_EN defined: a requester granted while its lock_x=1 SHALL keep exclusive grant on every cycle with req_x=1 and lock_x=1; the other requester SHALL stall.
REQ-018 Under lock, the lock SHALL release on the first cycle with lock_x=0 or req_x=0, and round-robin SHALL resume with the pointer set to the locking requester.
REQ-019 Macro RES_ARB_LOCK_EN undefined: lock_a and lock_b SHALL be ignored, and behaviour SHALL be pure round-robin per REQ-005.

Verification
REQ-020 A writes addr 14'h0005 data 8'h3C, then B reads 14'h0005 the next cycle -> res_wr in c+1, res_rd in c+2, rvalid_b in c+3 with rdata_b=8'h3C, rvalid_a never high.
REQ-021 A and B both hold read requests for 6 cycles right after reset -> grants alternate A,B,A,B,A,B, and res_rd is high on 6 consecutive cycles.
REQ-022 A alone issues reads of 14'h0000..14'h3FFF back-to-back -> 16384 consecutive grants, each rvalid_a arriving exactly 2 cycles after its grant with correct data.
REQ-023 Reset asserted in the cycle after a read grant -> res_rd drops to 0 asynchronously, and no rvalid follows after reset releases.
REQ-024 With RES_ARB_LOCK_EN defined, A holds req_a=1 and lock_a=1 for 4 cycles while B requests -> gnt_a 4 cycles, gnt_b 0, then gnt_b in cycle 5; without the macro -> grants alternate A,B from the first contention.

Source files
------------

// File: rtl/res_arb.sv
// Two-requester round-robin arbiter in front of a single-port resource RAM.
// Define RES_ARB_LOCK_EN to let a requester hold the grant via lock_a/lock_b.
module res_arb #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          wr_a,
  input  logic          wr_b,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_a,
  input  logic [DW-1:0] wdata_b,
  input  logic          lock_a,
  input  logic          lock_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic          res_rd,
  output logic          res_wr,
  output logic [AW-1:0] res_addr,
  output logic [DW-1:0] res_do,
  input  logic [DW-1:0] res_di,
  output logic          busy
);

  logic                last_b;   // 1: B was granted most recently
  logic                rd_tag;   // issuer of the read on the RAM port (1 = B)
  logic                hold_a, hold_b;
  logic [1:0]          rd_sel;
  logic [1:0]          rv_q;
  logic [1:0][DW-1:0]  rdata_q;

`ifdef RES_ARB_LOCK_EN
  logic lock_own_a, lock_own_b;

  assign hold_a = lock_own_a & req_a & lock_a;
  assign hold_b = lock_own_b & req_b & lock_b;

  // Ownership only survives while the owner keeps being granted with lock set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_own_a <= 1'b0;
      lock_own_b <= 1'b0;
    end else begin
      lock_own_a <= gnt_a & lock_a;
      lock_own_b <= gnt_b & lock_b;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = lock_a ^ lock_b;
  assign hold_a = 1'b0;
  assign hold_b = 1'b0;
`endif

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!reset) begin
      if (hold_a)              gnt_a = 1'b1;
      else if (hold_b)         gnt_b = 1'b1;
      else if (req_a && req_b) begin
        gnt_a = last_b;
        gnt_b = ~last_b;
      end
      else if (req_a)          gnt_a = 1'b1;
      else if (req_b)          gnt_b = 1'b1;
    end
  end

  // Command stage: one registered command per granted cycle, in grant order
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_b   <= 1'b1;
      rd_tag   <= 1'b0;
      res_rd   <= 1'b0;
      res_wr   <= 1'b0;
      res_addr <= '0;
      res_do   <= '0;
    end else begin
      res_rd <= (gnt_a & ~wr_a) | (gnt_b & ~wr_b);
      res_wr <= (gnt_a &  wr_a) | (gnt_b &  wr_b);
      if (gnt_a || gnt_b) begin
        last_b   <= gnt_b;
        rd_tag   <= gnt_b;
        res_addr <= gnt_b ? addr_b  : addr_a;
        res_do   <= gnt_b ? wdata_b : wdata_a;
      end
    end
  end

  assign rd_sel = {res_rd & rd_tag, res_rd & ~rd_tag};

  // Return stage: RAM data is valid by the posedge closing the res_rd cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rv_q    <= '0;
      rdata_q <= '0;
    end else begin
      rv_q <= rd_sel;
      for (int i = 0; i < 2; i++)
        if (rd_sel[i]) rdata_q[i] <= res_di;
    end
  end

  assign rvalid_a = rv_q[0];
  assign rvalid_b = rv_q[1];
  assign rdata_a  = rdata_q[0];
  assign rdata_b  = rdata_q[1];
  assign busy     = res_rd | res_wr | (|rv_q);

endmodule

// File: tb/tb_res_arb.sv
// Directed bench for res_arb: vector table plus hand-written multi-cycle sequences.
module tb_res_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b, wr_a, wr_b, lock_a, lock_b;
  logic [13:0] addr_a, addr_b;
  logic [7:0]  wdata_a, wdata_b;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [7:0]  rdata_a, rdata_b;
  logic        res_rd, res_wr;
  logic [13:0] res_addr;
  logic [7:0]  res_do, res_di;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  res_arb #(.AW(14), .DW(8)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .wr_a(wr_a), .wr_b(wr_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .lock_a(lock_a), .lock_b(lock_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do),
    .res_di(res_di), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM model; contents stored as XOR against the power-on pattern addr[7:0]^5A
  bit [7:0] mem_d [0:16383];
  always @(negedge clk) if (res_rd) res_di <= mem_d[res_addr] ^ res_addr[7:0] ^ 8'h5A;
  always @(posedge clk) if (res_wr) mem_d[res_addr] <= res_do ^ res_addr[7:0] ^ 8'h5A;

  // Expected RAM contents after the writes the vector table performs
  function automatic logic [7:0] exp_mem(input logic [13:0] a);
    if (a == 14'h0005) return 8'h3C;
    if (a == 14'h0030) return 8'h99;
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    req_a = 1'b0; req_b = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
    lock_a = 1'b0; lock_b = 1'b0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ctl = {req_a,req_b,wr_a,wr_b}; ex = {gnt_a,gnt_b,res_rd,res_wr,rvalid_a,rvalid_b,busy}
  typedef struct packed {
    logic [3:0]  ctl;
    logic [13:0] aa, ab;
    logic [7:0]  da, db;
    logic [6:0]  ex;
    logic [13:0] eaddr;
    logic [7:0]  edo, erdat;
  } vec_t;

  vec_t tbl [0:13];

  logic [1:0] exp_g;

  initial begin
    tbl[0]  = '{4'b1010, 14'h005, 14'h000, 8'h3C, 8'h00, 7'b1000000, 14'h000, 8'h00, 8'h00};
    tbl[1]  = '{4'b0100, 14'h000, 14'h005, 8'h00, 8'h00, 7'b0101001, 14'h005, 8'h3C, 8'h00};
    tbl[2]  = '{4'b0000, 14'h000, 14'h000, 8'h00, 8'h00, 7'b0010001, 14'h005, 8'h00, 8'h00};
    tbl[3]  = '{4'b0000, 14'h000, 14'h000, 8'h00, 8'h00, 7'b0000011, 14'h005, 8'h00, 8'h3C};
    tbl[4]  = '{4'b1100, 14'h010, 14'h020, 8'h00, 8'h00, 7'b1000000, 14'h005, 8'h00, 8'h00};
    tbl[5]  = '{4'b1100, 14'h011, 14'h021, 8'h00, 8'h00, 7'b0110001, 14'h010, 8'h00, 8'h00};
    tbl[6]  = '{4'b1100, 14'h012, 14'h022, 8'h00, 8'h00, 7'b1010101, 14'h021, 8'h00, 8'h4A};
    tbl[7]  = '{4'b0000, 14'h000, 14'h000, 8'h00, 8'h00, 7'b0010011, 14'h012, 8'h00, 8'h7B};
    tbl[8]  = '{4'b0000, 14'h000, 14'h000, 8'h00, 8'h00, 7'b0000101, 14'h012, 8'h00, 8'h48};
    tbl[9]  = '{4'b0000, 14'h000, 14'h000, 8'h00, 8'h00, 7'b0000000, 14'h012, 8'h00, 8'h00};
    tbl[10] = '{4'b0101, 14'h000, 14'h030, 8'h00, 8'h99, 7'b0100000, 14'h012, 8'h00, 8'h00};
    tbl[11] = '{4'b1000, 14'h030, 14'h000, 8'h00, 8'h00, 7'b1001001, 14'h030, 8'h99, 8'h00};
    tbl[12] = '{4'b0000, 14'h000, 14'h000, 8'h00, 8'h00, 7'b0010001, 14'h030, 8'h00, 8'h00};
    tbl[13] = '{4'b0000, 14'h000, 14'h000, 8'h00, 8'h00, 7'b0000101, 14'h030, 8'h00, 8'h99};

    // Reset state, with requests asserted to show grants are masked
    idle();
    reset = 1'b1;
    req_a = 1'b1; req_b = 1'b1;
    #3;
    chk("rst_gnt", 32'({gnt_a, gnt_b}), 32'h0);
    chk("rst_cmd", 32'({res_rd, res_wr, res_addr, res_do}), 32'h0);
    chk("rst_ret", 32'({rvalid_a, rvalid_b, rdata_a, rdata_b, busy}), 32'h0);
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Vector table straight out of reset
    for (int i = 0; i < 14; i++) begin
      step();
      {req_a, req_b, wr_a, wr_b} = tbl[i].ctl;
      addr_a = tbl[i].aa; addr_b = tbl[i].ab;
      wdata_a = tbl[i].da; wdata_b = tbl[i].db;
      #2;
      chk($sformatf("vec%0d_ctl", i),
          32'({gnt_a, gnt_b, res_rd, res_wr, rvalid_a, rvalid_b, busy}), 32'(tbl[i].ex));
      chk($sformatf("vec%0d_addr", i), 32'(res_addr), 32'(tbl[i].eaddr));
      if (tbl[i].ex[3]) chk($sformatf("vec%0d_do", i), 32'(res_do), 32'(tbl[i].edo));
      if (tbl[i].ex[2]) chk($sformatf("vec%0d_rda", i), 32'(rdata_a), 32'(tbl[i].erdat));
      if (tbl[i].ex[1]) chk($sformatf("vec%0d_rdb", i), 32'(rdata_b), 32'(tbl[i].erdat));
    end

    // Full-range back-to-back reads from A: grant every cycle, data 2 cycles later
    for (int k = 0; k < 16387; k++) begin
      step();
      idle();
      if (k < 16384) begin
        req_a = 1'b1;
        addr_a = 14'(k);
      end
      #2;
      if (k < 16384) chk("sweep_gnt", 32'({gnt_a, gnt_b}), 32'h2);
      if (k >= 2 && k < 16386) begin
        chk("sweep_rv", 32'({rvalid_a, rvalid_b}), 32'h2);
        chk("sweep_data", 32'(rdata_a), 32'(exp_mem(14'(k - 2))));
      end
      if (k == 16386) chk("sweep_tail", 32'({rvalid_a, rvalid_b, busy}), 32'h0);
    end

    // Six cycles of contention right after reset: strict alternation, res_rd solid
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step();
      idle();
      if (i < 6) begin
        req_a = 1'b1; req_b = 1'b1;
        addr_a = 14'(i); addr_b = 14'(16'h100 + i);
      end
      #2;
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      if (i < 6) chk($sformatf("alt%0d_gnt", i), 32'({gnt_a, gnt_b}), 32'(exp_g));
      if (i >= 1) chk($sformatf("alt%0d_rd", i), 32'(res_rd), 32'h1);
    end

    // Lock: A locks for 4 cycles, drops, then both contend without lock
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      idle();
      req_b = 1'b1;
      req_a  = (i != 4);
      lock_a = (i < 4);
`ifdef RES_ARB_LOCK_EN
      exp_g = (i < 4 || i == 5) ? 2'b10 : 2'b01;
`else
      exp_g = (i == 0 || i == 2 || i == 5) ? 2'b10 : 2'b01;
`endif
      #2;
      chk($sformatf("lock%0d_gnt", i), 32'({gnt_a, gnt_b}), 32'(exp_g));
    end

    // Reset in the cycle after a read grant: command drops at once, no late rvalid
    do_reset();
    step();
    req_a = 1'b1; addr_a = 14'h0007;
    #2;
    chk("mid_gnt", 32'(gnt_a), 32'h1);
    step();
    idle();
    #2;
    chk("mid_rd_pre", 32'(res_rd), 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rd_async", 32'({res_rd, busy}), 32'h0);
    req_a = 1'b1; req_b = 1'b1;
    #1;
    chk("mid_gnt_rst", 32'({gnt_a, gnt_b}), 32'h0);
    step();
    step();
    idle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("mid_norv%0d", i), 32'({rvalid_a, rvalid_b, res_rd, busy}), 32'h0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
